// File: rtl/bcd_timer_entry.sv
// bcd_timer_entry: keypad-loaded 3-digit BCD countdown timer (M:SS) feeding the display driver.
// Optional QUICK_START_EN: start at 0:00 loads 0:30, start while running adds 30 s (saturating at 9:59).
module bcd_timer_entry #(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       tick_in,
  output logic [3:0] min_out,
  output logic [3:0] dseg_out,
  output logic [3:0] seg_out,
  output logic       running,
  output logic       done
);
  typedef enum logic [1:0] {ENTRY, RUN, PAUSE} state_t;
  state_t      state_q, state_d;
  logic [11:0] tm_q, tm_d, run_t;
  logic [9:0]  pre_q, pre_d;
  logic        done_q, done_d, wrap;
  // Folds an over-range tens digit into minutes; 9:6x and above clamp to 9:59.
  function automatic logic [11:0] carry(input logic [11:0] t);
    return t[7:4] > 4'd5 ? (t[11:8] == 4'd9 ? 12'h959 : {t[11:8] + 4'd1, t[7:4] - 4'd6, t[3:0]}) : t;
  endfunction
  function automatic logic [11:0] dec(input logic [11:0] t);
    return t[3:0] != 4'd0 ? {t[11:4], t[3:0] - 4'd1} :
           t[7:4] != 4'd0 ? {t[11:8], t[7:4] - 4'd1, 4'd9} :
           t[11:8] != 4'd0 ? {t[11:8] - 4'd1, 8'h59} : t;
  endfunction
`ifdef QUICK_START_EN
  function automatic logic [11:0] add30(input logic [11:0] t);
    return carry({t[11:8], t[7:4] + 4'd3, t[3:0]});
  endfunction
`endif
  assign wrap = tick_in && pre_q == 10'(TICKS_PER_SEC - 1);
  always_comb begin
    state_d = state_q;
    tm_d    = tm_q;
    pre_d   = pre_q;
    done_d  = 1'b0;
    run_t   = wrap ? dec(tm_q) : tm_q;
`ifdef QUICK_START_EN
    if (start) run_t = add30(run_t);
`endif
    if (state_q == ENTRY) begin
      if (stop_clear) tm_d = 12'h000;
      else if (start) begin
        if (tm_q != 12'h000) begin
          tm_d    = carry(tm_q);
          state_d = RUN;
          pre_d   = 10'd0;
        end
`ifdef QUICK_START_EN
        else begin
          tm_d    = 12'h030;
          state_d = RUN;
          pre_d   = 10'd0;
        end
`endif
      end else if (key_valid && key_code <= 4'd9) tm_d = {tm_q[7:0], key_code};
    end else if (state_q == RUN) begin
      if (stop_clear) state_d = PAUSE;
      else begin
        tm_d  = run_t;
        pre_d = tick_in ? (wrap ? 10'd0 : pre_q + 10'd1) : pre_q;
        if (wrap && run_t == 12'h000) begin
          done_d  = 1'b1;
          state_d = ENTRY;
        end
      end
    end else begin
      if (stop_clear) begin
        tm_d    = 12'h000;
        state_d = ENTRY;
        pre_d   = 10'd0;
      end else if (start) state_d = RUN;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENTRY;
      tm_q    <= 12'h000;
      pre_q   <= 10'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tm_q    <= tm_d;
      pre_q   <= pre_d;
      done_q  <= done_d;
    end
  end
  assign min_out  = tm_q[11:8];
  assign dseg_out = tm_q[7:4];
  assign seg_out  = tm_q[3:0];
  assign running  = state_q == RUN;
  assign done     = done_q;
endmodule

// File: tb/tb_bcd_timer_entry.sv
// tb_bcd_timer_entry: directed self-checking bench for bcd_timer_entry with TICKS_PER_SEC=4.
module tb_bcd_timer_entry;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       key_valid = 1'b0, start = 1'b0, stop_clear = 1'b0, tick_in = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [3:0] min_out, dseg_out, seg_out;
  logic       running, done;
  logic [11:0] t;
  int checks = 0, failures = 0;
  bcd_timer_entry #(.TICKS_PER_SEC(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .start(start), .stop_clear(stop_clear), .tick_in(tick_in),
    .min_out(min_out), .dseg_out(dseg_out), .seg_out(seg_out),
    .running(running), .done(done)
  );
  always #5 clk = ~clk;
  assign t = {min_out, dseg_out, seg_out};
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic key(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    step();
    key_valid = 1'b0;
  endtask
  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic do_stop();
    stop_clear = 1'b1;
    step();
    stop_clear = 1'b0;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_in = 1'b1;
      step();
      tick_in = 1'b0;
    end
  endtask
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (t !== 12'h000) begin failures++; $display("FAIL reset_time got=%h exp=%h", t, 12'h000); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_entry();
    key(4'd1); key(4'd3); key(4'd0);
    checks++; if (t !== 12'h130) begin failures++; $display("FAIL keys_130 got=%h exp=%h", t, 12'h130); end
    key(4'd4);
    checks++; if (t !== 12'h304) begin failures++; $display("FAIL key4_shift got=%h exp=%h", t, 12'h304); end
    key(4'd12);
    checks++; if (t !== 12'h304) begin failures++; $display("FAIL key12_ignored got=%h exp=%h", t, 12'h304); end
    do_stop();
    checks++; if (t !== 12'h000) begin failures++; $display("FAIL entry_clear got=%h exp=%h", t, 12'h000); end
  endtask
  task automatic test_normalize();
    key(4'd0); key(4'd9); key(4'd0);
    do_start();
    checks++; if (t !== 12'h130) begin failures++; $display("FAIL norm_090 got=%h exp=%h", t, 12'h130); end
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL norm_running got=%b exp=1", running); end
    do_stop(); do_stop();
    checks++; if (t !== 12'h000 || running !== 1'b0) begin failures++; $display("FAIL norm_clear got=%h/%b exp=000/0", t, running); end
    key(4'd9); key(4'd9); key(4'd9);
    do_start();
    checks++; if (t !== 12'h959) begin failures++; $display("FAIL norm_sat got=%h exp=%h", t, 12'h959); end
    do_stop(); do_stop();
  endtask
  task automatic test_countdown();
    key(4'd1); key(4'd0); key(4'd0);
    do_start();
    ticks(3);
    checks++; if (t !== 12'h100) begin failures++; $display("FAIL prescale_hold got=%h exp=%h", t, 12'h100); end
    ticks(1);
    checks++; if (t !== 12'h059) begin failures++; $display("FAIL borrow_min got=%h exp=%h", t, 12'h059); end
    ticks(4);
    checks++; if (t !== 12'h058) begin failures++; $display("FAIL second_dec got=%h exp=%h", t, 12'h058); end
    do_stop(); do_stop();
  endtask
  task automatic test_done();
    key(4'd0); key(4'd0); key(4'd2);
    do_start();
    ticks(4);
    checks++; if (t !== 12'h001 || done !== 1'b0) begin failures++; $display("FAIL done_001 got=%h/%b exp=001/0", t, done); end
    ticks(3);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_early got=%b exp=0", done); end
    ticks(1);
    checks++; if (t !== 12'h000) begin failures++; $display("FAIL done_time got=%h exp=%h", t, 12'h000); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL done_pulse got=%b exp=1", done); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL done_running got=%b exp=0", running); end
    step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%b exp=0", done); end
    ticks(1);
    checks++; if (t !== 12'h000 || running !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL done_after_tick got=%h/%b/%b exp=000/0/0", t, running, done); end
    key(4'd6);
    checks++; if (t !== 12'h006) begin failures++; $display("FAIL done_entry got=%h exp=%h", t, 12'h006); end
    do_stop();
  endtask
  task automatic test_pause();
    key(4'd0); key(4'd4); key(4'd5);
    do_start();
    ticks(2);
    do_stop();
    checks++; if (t !== 12'h045 || running !== 1'b0) begin failures++; $display("FAIL pause_hold got=%h/%b exp=045/0", t, running); end
    ticks(8);
    checks++; if (t !== 12'h045) begin failures++; $display("FAIL pause_ticks got=%h exp=%h", t, 12'h045); end
    key(4'd7);
    checks++; if (t !== 12'h045) begin failures++; $display("FAIL pause_key got=%h exp=%h", t, 12'h045); end
    do_start();
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL resume_running got=%b exp=1", running); end
    ticks(1);
    checks++; if (t !== 12'h045) begin failures++; $display("FAIL resume_pre_early got=%h exp=%h", t, 12'h045); end
    ticks(1);
    checks++; if (t !== 12'h044) begin failures++; $display("FAIL resume_pre_held got=%h exp=%h", t, 12'h044); end
    do_stop(); do_stop();
    checks++; if (t !== 12'h000 || running !== 1'b0) begin failures++; $display("FAIL pause_clear got=%h/%b exp=000/0", t, running); end
    key(4'd0); key(4'd4); key(4'd5);
    do_start();
    do_stop();
    start = 1'b1; stop_clear = 1'b1;
    step();
    start = 1'b0; stop_clear = 1'b0;
    checks++; if (t !== 12'h000 || running !== 1'b0) begin failures++; $display("FAIL pause_both got=%h/%b exp=000/0", t, running); end
    key(4'd7);
    checks++; if (t !== 12'h007) begin failures++; $display("FAIL pause_both_entry got=%h exp=%h", t, 12'h007); end
    do_stop();
  endtask
  task automatic test_priority();
    key(4'd1); key(4'd0); key(4'd0);
    start = 1'b1; key_valid = 1'b1; key_code = 4'd5;
    step();
    start = 1'b0; key_valid = 1'b0;
    checks++; if (t !== 12'h100 || running !== 1'b1) begin failures++; $display("FAIL start_beats_key got=%h/%b exp=100/1", t, running); end
    ticks(3);
    stop_clear = 1'b1; tick_in = 1'b1;
    step();
    stop_clear = 1'b0; tick_in = 1'b0;
    checks++; if (t !== 12'h100 || running !== 1'b0) begin failures++; $display("FAIL stop_beats_tick got=%h/%b exp=100/0", t, running); end
    do_start();
    ticks(1);
    checks++; if (t !== 12'h059) begin failures++; $display("FAIL stop_tick_resume got=%h exp=%h", t, 12'h059); end
    do_stop(); do_stop();
  endtask
  task automatic test_quick();
    do_start();
`ifdef QUICK_START_EN
    checks++; if (t !== 12'h030 || running !== 1'b1) begin failures++; $display("FAIL quick_zero got=%h/%b exp=030/1", t, running); end
`else
    checks++; if (t !== 12'h000 || running !== 1'b0) begin failures++; $display("FAIL quick_zero got=%h/%b exp=000/0", t, running); end
`endif
    do_stop(); do_stop();
    key(4'd9); key(4'd4); key(4'd5);
    do_start();
    do_start();
`ifdef QUICK_START_EN
    checks++; if (t !== 12'h959) begin failures++; $display("FAIL quick_add got=%h exp=%h", t, 12'h959); end
`else
    checks++; if (t !== 12'h945) begin failures++; $display("FAIL quick_add got=%h exp=%h", t, 12'h945); end
`endif
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL quick_add_running got=%b exp=1", running); end
    do_stop(); do_stop();
  endtask
  task automatic test_async_reset();
    key(4'd1); key(4'd0); key(4'd0);
    do_start();
    ticks(2);
    rst_n = 1'b0;
    #1;
    checks++; if (t !== 12'h000 || running !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL async_reset got=%h/%b/%b exp=000/0/0", t, running, done); end
    @(negedge clk);
    rst_n = 1'b1;
    ticks(8);
    checks++; if (t !== 12'h000 || running !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL after_reset got=%h/%b/%b exp=000/0/0", t, running, done); end
  endtask
  initial begin
    test_reset();
    test_entry();
    test_normalize();
    test_countdown();
    test_done();
    test_pause();
    test_priority();
    test_quick();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
